// File: rtl/run_stats_if.sv
// ---------------------------------------------------------------------------
// run_stats_if
// Record-drain handshake between run_stats and its consumer.
//
//   out_valid  producer -> consumer  head record available
//   out_len    producer -> consumer  run length of head record (CW bits)
//   out_ready  consumer -> producer  head accepted this cycle
//
// Modports: master = run_stats (record producer), slave = consumer.
// ---------------------------------------------------------------------------
interface run_stats_if #(
    parameter int CW = 8
);
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_len;

    modport master (
        output out_valid,
        output out_len,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_len,
        output out_ready
    );
endinterface

// File: rtl/run_stats.sv
// ---------------------------------------------------------------------------
// run_stats
// Turns the sequence detector's Mealy pulses into run-length records.
// Z2 pulses (run continuing) are counted in a saturating accumulator; a Z1
// pulse (run ended) closes the run, queues its length in a small FIFO that is
// drained over a valid/ready handshake, and updates running totals.
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-low
//   Z1          run-end pulse
//   Z2          run-continue pulse
//   out_if      record handshake (master): out_valid, out_len, out_ready
//   run_count   completed runs since reset (pushed or dropped), saturating
//   max_run     longest completed run since reset (0 without RUN_STATS_MAX_EN)
//   drop_count  records lost to a full FIFO, saturating
//   err         sticky flag: Z1 and Z2 seen high in the same cycle
//
// Build option
//   RUN_STATS_MAX_EN  when defined, the max_run register and comparator are
//                     built; otherwise max_run is tied to 0.
// ---------------------------------------------------------------------------
module run_stats #(
    parameter int CW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Z1,
    input  logic          Z2,
    run_stats_if.master   out_if,
    output logic [CW-1:0] run_count,
    output logic [CW-1:0] max_run,
    output logic [CW-1:0] drop_count,
    output logic          err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;

    typedef logic [CW-1:0] word_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [NW-1:0] cnt_t;

    localparam word_t WORD_MAX = {CW{1'b1}};
    localparam cnt_t  CNT_FULL = cnt_t'(DEPTH);

    // Saturating increment shared by the accumulator and both counters.
    function automatic word_t sat_inc(input word_t v);
        return (v == WORD_MAX) ? v : v + word_t'(1);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    word_t acc_q, acc_d;
    ptr_t  wptr_q, wptr_d;
    ptr_t  rptr_q, rptr_d;
    cnt_t  cnt_q, cnt_d;
    word_t run_count_q, run_count_d;
    word_t drop_count_q, drop_count_d;
    logic  err_q, err_d;

    // Record storage is data only; it is never reset because out_len is
    // masked to 0 whenever the FIFO is empty.
    word_t mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
    assign pop   = !empty && out_if.out_ready;
    // A full FIFO still takes the record when the head leaves the same cycle.
    assign push  = Z1 && (!full || pop);
    assign drop  = Z1 && !push;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        acc_d        = acc_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        run_count_d  = run_count_q;
        drop_count_d = drop_count_q;
        err_d        = err_q;

        // Z1 has priority: a simultaneous Z2 is a protocol error and must not
        // extend the run being closed.
        if (Z1) begin
            acc_d = '0;
        end else if (Z2) begin
            acc_d = sat_inc(acc_q);
        end

        if (push) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ptr_t'(1);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase

        if (Z1) begin
            run_count_d = sat_inc(run_count_q);
        end
        if (drop) begin
            drop_count_d = sat_inc(drop_count_q);
        end
        if (Z1 && Z2) begin
            err_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            run_count_q  <= '0;
            drop_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            run_count_q  <= run_count_d;
            drop_count_q <= drop_count_d;
            err_q        <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Record storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wptr_q] <= acc_q;
        end
    end

    // -----------------------------------------------------------------------
    // Longest run
    // -----------------------------------------------------------------------
`ifdef RUN_STATS_MAX_EN
    word_t max_run_q, max_run_d;

    // Dropped records still count toward the maximum.
    always_comb begin
        max_run_d = max_run_q;
        if (Z1 && (acc_q > max_run_q)) begin
            max_run_d = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            max_run_q <= '0;
        end else begin
            max_run_q <= max_run_d;
        end
    end

    assign max_run = max_run_q;
`else
    assign max_run = '0;
`endif

    // -----------------------------------------------------------------------
    // Outputs, all decoded from registers
    // -----------------------------------------------------------------------
    assign out_if.out_valid = !empty;
    assign out_if.out_len   = empty ? '0 : mem_q[rptr_q];
    assign run_count        = run_count_q;
    assign drop_count       = drop_count_q;
    assign err              = err_q;

endmodule

// File: tb/tb_run_stats.sv
// ---------------------------------------------------------------------------
// tb_run_stats
// Drives two run_stats instances (CW=8 and CW=4, DEPTH=4) with the same
// Z1/Z2/out_ready/reset stimulus and compares every output after each edge
// against a queue-based model of run records. Directed scenarios come first,
// followed by a randomized stretch.
// ---------------------------------------------------------------------------
module tb_run_stats;

    localparam int DEPTH = 4;
`ifdef RUN_STATS_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic z1;
    logic z2;

    logic [7:0] rc8, mx8, dc8;
    logic [3:0] rc4, mx4, dc4;
    logic       err8, err4;

    run_stats_if #(.CW(8)) if8 ();
    run_stats_if #(.CW(4)) if4 ();

    run_stats #(.CW(8), .DEPTH(DEPTH)) u_dut8 (
        .clk        (clk),
        .reset      (rst_n),
        .Z1         (z1),
        .Z2         (z2),
        .out_if     (if8),
        .run_count  (rc8),
        .max_run    (mx8),
        .drop_count (dc8),
        .err        (err8)
    );

    run_stats #(.CW(4), .DEPTH(DEPTH)) u_dut4 (
        .clk        (clk),
        .reset      (rst_n),
        .Z1         (z1),
        .Z2         (z2),
        .out_if     (if4),
        .run_count  (rc4),
        .max_run    (mx4),
        .drop_count (dc4),
        .err        (err4)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state, index 0 = CW 8, index 1 = CW 4.
    int lim [2] = '{255, 15};
    int macc[2];
    int mrc [2];
    int mdc [2];
    int mmax[2];
    int merr[2];
    int q8[$];
    int q4[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock edge of the record-level behaviour.
    task automatic model_edge(input bit rn, input bit i1, input bit i2, input bit rdy);
        for (int k = 0; k < 2; k++) begin : per_width
            int  sz;
            bit  popped;
            int  rec;
            if (!rn) begin
                macc[k] = 0; mrc[k] = 0; mdc[k] = 0; mmax[k] = 0; merr[k] = 0;
                if (k == 0) q8.delete(); else q4.delete();
            end else begin
                sz     = (k == 0) ? q8.size() : q4.size();
                popped = (sz != 0) && rdy;
                if (popped) begin
                    if (k == 0) void'(q8.pop_front()); else void'(q4.pop_front());
                end
                if (i1) begin
                    rec     = macc[k];
                    mrc[k]  = min2(mrc[k] + 1, lim[k]);
                    if (MAX_EN && rec > mmax[k]) mmax[k] = rec;
                    if (sz < DEPTH || popped) begin
                        if (k == 0) q8.push_back(rec); else q4.push_back(rec);
                    end else begin
                        mdc[k] = min2(mdc[k] + 1, lim[k]);
                    end
                    macc[k] = 0;
                    if (i2) merr[k] = 1;
                end else if (i2) begin
                    macc[k] = min2(macc[k] + 1, lim[k]);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("d8.valid", int'(if8.out_valid), (q8.size() != 0) ? 1 : 0);
        chk("d8.len",   int'(if8.out_len),   (q8.size() != 0) ? q8[0] : 0);
        chk("d8.runs",  int'(rc8),  mrc[0]);
        chk("d8.max",   int'(mx8),  mmax[0]);
        chk("d8.drops", int'(dc8),  mdc[0]);
        chk("d8.err",   int'(err8), merr[0]);
        chk("d4.valid", int'(if4.out_valid), (q4.size() != 0) ? 1 : 0);
        chk("d4.len",   int'(if4.out_len),   (q4.size() != 0) ? q4[0] : 0);
        chk("d4.runs",  int'(rc4),  mrc[1]);
        chk("d4.max",   int'(mx4),  mmax[1]);
        chk("d4.drops", int'(dc4),  mdc[1]);
        chk("d4.err",   int'(err4), merr[1]);
    endtask

    // Drive inputs away from the edge, clock once, update model, check.
    task automatic step(input bit rn, input bit i1, input bit i2, input bit rdy);
        rst_n         = rn;
        z1            = i1;
        z2            = i2;
        if8.out_ready = rdy;
        if4.out_ready = rdy;
        @(posedge clk);
        model_edge(rn, i1, i2, rdy);
        #1;
        check_all();
    endtask

    task automatic run_len(input int len, input bit rdy);
        repeat (len) step(1'b1, 1'b0, 1'b1, rdy);
        step(1'b1, 1'b1, 1'b0, rdy);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; z1 = 1'b0; z2 = 1'b0;
        if8.out_ready = 1'b0;
        if4.out_ready = 1'b0;
        foreach (macc[k]) begin
            macc[k] = 0; mrc[k] = 0; mdc[k] = 0; mmax[k] = 0; merr[k] = 0;
        end

        // Reset state
        do_reset();
        chk("rst.valid", int'(if8.out_valid), 0);
        chk("rst.len",   int'(if8.out_len), 0);

        // Run of length 3 held in the FIFO
        run_len(3, 1'b0);
        chk("run3.valid", int'(if8.out_valid), 1);
        chk("run3.len",   int'(if8.out_len), 3);
        chk("run3.runs",  int'(rc8), 1);
        chk("run3.max",   int'(mx8), MAX_EN ? 3 : 0);

        // Five runs into a depth-4 FIFO, then drain
        do_reset();
        for (int l = 0; l < 5; l++) run_len(l, 1'b0);
        chk("ovf.drops", int'(dc8), 1);
        chk("ovf.runs",  int'(rc8), 5);
        for (int i = 0; i < 4; i++) begin
            chk("drain.len", int'(if8.out_len), i);
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("drain.empty", int'(if8.out_valid), 0);

        // Full FIFO with push and pop on the same edge
        do_reset();
        for (int l = 0; l < 4; l++) run_len(l, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("fullpp.drops", int'(dc8), 0);
        chk("fullpp.head",  int'(if8.out_len), 1);
        for (int i = 0; i < 4; i++) begin
            chk("fullpp.drain", int'(if8.out_len), (i < 3) ? i + 1 : 2);
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("fullpp.empty", int'(if8.out_valid), 0);

        // Accumulator saturation
        do_reset();
        run_len(20, 1'b0);
        chk("sat.len4", int'(if4.out_len), 15);
        chk("sat.len8", int'(if8.out_len), 20);

        // Z1 and Z2 together: Z1 wins, err sticks until reset
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("perr.len", int'(if8.out_len), 2);
        chk("perr.err", int'(err8), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        run_len(1, 1'b0);
        chk("perr.acc0", int'(if8.out_len), 1);
        chk("perr.hold", int'(err8), 1);

        // Reset mid-run with two records queued
        do_reset();
        run_len(0, 1'b0);
        run_len(1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("mrst.valid", int'(if8.out_valid), 0);
        chk("mrst.len",   int'(if8.out_len), 0);
        chk("mrst.runs",  int'(rc8), 0);
        chk("mrst.err",   int'(err8), 0);
        chk("mrst.drops", int'(dc8), 0);
        run_len(1, 1'b0);
        chk("mrst.len1",  int'(if8.out_len), 1);
        chk("mrst.runs1", int'(rc8), 1);

        // Z1 every cycle with ready held never drops
        do_reset();
        repeat (12) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("thru.drops", int'(dc8), 0);

        // Randomized stretch
        do_reset();
        for (int n = 0; n < 1500; n++) begin : rnd
            int  r;
            bit  rn, i1, i2, rdy;
            r   = $urandom_range(0, 99);
            i1  = (r < 25) || (r == 99);
            i2  = (r >= 25);
            rdy = ($urandom_range(0, 3) != 0) ^ ((n / 200) % 2 == 1);
            rn  = ($urandom_range(0, 299) != 0);
            step(rn, i1, i2, rdy);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
